cnu_minsum: RTL
===============

Name: cnu_minsum

Overview:
- Layered min-sum check-node unit for the QC-LDPC decoder.
- Sits directly downstream of the quasi-cyclic shift network and consumes one block column per beat: LiftingFactor shifted variable-to-check LLRs.
- Runs a two-phase row operation. ACCUM collects min1, min2, the min1 column index and sign parity per lane. EMIT streams back one check-to-variable message vector per column for the inverse shift and the posterior update.

Parameters:
- DWIDTH, 8, LLR width in bits, two's complement; matches configs package.
- LiftingFactor, 4, lanes per beat (Z); matches configs package.
- MAX_DEG, 8, maximum row degree (block columns per layer row).
- OFFSET, 0, offset-min-sum beta subtracted from output magnitudes.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit can accept a beat.
- in_data  in  DWIDTH x LiftingFactor (unpacked)  shifted LLRs for one column.
- in_last  in  1  final column of the current row.
- out_valid  out  1  message beat valid.
- out_ready  in  1  downstream accepts the message beat.
- out_data  out  DWIDTH x LiftingFactor (unpacked)  check-to-variable messages.
- out_last  out  1  final column of the row.
- deg_err  out  1  sticky: row exceeded MAX_DEG.

Behaviour:
- Reset (async, rst_n=0):
  - state=ACCUM, column counter 0.
  - Per lane: min1 and min2 = 2^(DWIDTH-1)-1, idx=0, parity=0.
  - out_valid=0, out_data=0, out_last=0, deg_err=0.
  - in_ready=1 once out of reset.
- Reset mid-row or mid-emit abandons the row entirely; no partial output follows.
- Magnitude: |x| with saturation, so -2^(DWIDTH-1) maps to 2^(DWIDTH-1)-1. Sign = MSB; zero counts as positive.
- ACCUM state:
  - in_ready=1, out_valid=0.
  - A beat is accepted when in_valid && in_ready.
  - Per accepted beat, per lane l, with m = magnitude:
    - m < min1: min2 <= min1, min1 <= m, idx <= col.
    - else if m < min2: min2 <= m.
    - Ties go to min2; idx keeps the first occurrence.
  - parity ^= sign. Sign bit stored in sign_buf[col][l]; col increments.
  - Accepted beat with in_last=1, or col==MAX_DEG-1: latch deg=col+1, go to EMIT.
  - If col==MAX_DEG-1 and in_last=0, set deg_err; it stays set until reset.
- EMIT state:
  - in_ready=0. out_valid=1 from the cycle after the last input beat is accepted (1-cycle latency).
  - Beat j in 0..deg-1, lane l:
    - mag = (j==idx ? min2 : min1); mag = max(mag-OFFSET, 0).
    - sign = parity ^ sign_buf[j][l].
    - out_data = sign ? -mag : mag.
  - out_data, out_last are registered and stay stable while out_valid && !out_ready.
  - out_last=1 on beat deg-1.
  - On the final handshake: clear per-lane accumulators to reset values, col=0, return to ACCUM. in_ready=1 the next cycle (no overlap of rows).
- Degree-1 row: min2 remains the saturation value, so the single message magnitude is 2^(DWIDTH-1)-1 (minus OFFSET).
- Lanes are fully independent; no cross-lane arithmetic.

Test Plan:
- Degree-3 row, lane0 = 5, -3, 7, out_ready=1 → out lane0 = -3, +5, -3; out_last on beat 3; first out_valid 1 cycle after the in_last handshake.
- Lane1 = -128, 10, -2, 4 (deg 4) → mags 127,10,2,4; parity 0 → out = -2, +2, -4, +2.
- Tie: lane2 = 6, 6, 9 → min1=6 idx0, min2=6 → out = 6, 6, 6.
- Backpressure: hold out_ready=0 for 5 cycles mid-emit → out_data and out_last stable; in_ready stays 0; no beat lost or duplicated.
- 8 beats with in_last=0 (MAX_DEG=8) → deg_err=1, 8 messages emitted; next row processes normally with deg_err still 1.
- Assert rst_n=0 during EMIT beat 2 → out_valid=0 immediately; after release a fresh degree-2 row (1, -1) yields -1, +1.

Source files
------------

// File: rtl/cnu_minsum.sv
`default_nettype none
// ============================================================================
// Module   : cnu_minsum
// Brief    : Layered min-sum check-node unit (ACCUM min1/min2/idx/parity,
//            then EMIT one check-to-variable vector per block column).
// Revision : 1.0 - initial release
// ============================================================================
module cnu_minsum #(
    parameter int DWIDTH        = 8,
    parameter int LiftingFactor = 4,
    parameter int MAX_DEG       = 8,
    parameter int OFFSET        = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data [LiftingFactor],
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data [LiftingFactor],
    output logic              out_last,
    output logic              deg_err
);

    localparam int                c_IW       = (MAX_DEG > 1) ? $clog2(MAX_DEG) : 1;
    localparam logic [c_IW-1:0]   c_LAST_COL = c_IW'(MAX_DEG - 1);
    localparam logic [DWIDTH-1:0] c_MAG_MAX  = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic [DWIDTH-1:0] c_MOST_NEG = {1'b1, {(DWIDTH-1){1'b0}}};
    localparam logic [DWIDTH-1:0] c_OFFSET   = DWIDTH'(OFFSET);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DWIDTH-1:0]        r_min1 [LiftingFactor];
    logic [DWIDTH-1:0]        r_min2 [LiftingFactor];
    logic [c_IW-1:0]          r_idx  [LiftingFactor];
    logic [LiftingFactor-1:0] r_par;
    logic [LiftingFactor-1:0] r_sign_buf [MAX_DEG];
    logic [c_IW-1:0]          r_col;
    logic [c_IW-1:0]          r_last_col;
    logic [c_IW-1:0]          r_j;

    logic [DWIDTH-1:0]        w_mag      [LiftingFactor];
    logic [LiftingFactor-1:0] w_sgn;
    logic [DWIDTH-1:0]        w_min1_nxt [LiftingFactor];
    logic [DWIDTH-1:0]        w_min2_nxt [LiftingFactor];
    logic [c_IW-1:0]          w_idx_nxt  [LiftingFactor];
    logic [LiftingFactor-1:0] w_par_nxt;
    logic [LiftingFactor-1:0] w_sign0;
    logic [DWIDTH-1:0]        w_first    [LiftingFactor];
    logic [DWIDTH-1:0]        w_next     [LiftingFactor];
    logic [c_IW-1:0]          w_jn;
    logic                     w_acc;
    logic                     w_last_acc;
    logic                     w_hs;
    logic                     w_done;

    // Saturating magnitude: the most negative code folds onto the largest positive.
    function automatic logic [DWIDTH-1:0] sat_abs(input logic [DWIDTH-1:0] x);
        if (!x[DWIDTH-1])
            return x;
        else if (x == c_MOST_NEG)
            return c_MAG_MAX;
        else
            return -x;
    endfunction

    function automatic logic [DWIDTH-1:0] msg(
        input logic [c_IW-1:0]   j,
        input logic [c_IW-1:0]   idx,
        input logic [DWIDTH-1:0] m1,
        input logic [DWIDTH-1:0] m2,
        input logic              s
    );
        logic [DWIDTH-1:0] mag;
        mag = (j == idx) ? m2 : m1;
        mag = (mag > c_OFFSET) ? (mag - c_OFFSET) : '0;
        return s ? -mag : mag;
    endfunction

    assign w_acc      = in_valid && (r_state == ACCUM);
    assign w_last_acc = w_acc && (in_last || (r_col == c_LAST_COL));
    assign w_hs       = out_valid && out_ready;
    assign w_done     = w_hs && out_last;
    assign w_jn       = r_j + c_IW'(1);

    // Beat 0 is built from the post-update accumulators so it can leave on
    // the cycle right after the final input handshake.
    always_comb begin
        for (int l = 0; l < LiftingFactor; l++) begin
            w_mag[l]      = sat_abs(in_data[l]);
            w_sgn[l]      = in_data[l][DWIDTH-1];
            w_min1_nxt[l] = r_min1[l];
            w_min2_nxt[l] = r_min2[l];
            w_idx_nxt[l]  = r_idx[l];
            if (w_mag[l] < r_min1[l]) begin
                w_min2_nxt[l] = r_min1[l];
                w_min1_nxt[l] = w_mag[l];
                w_idx_nxt[l]  = r_col;
            end else if (w_mag[l] < r_min2[l]) begin
                w_min2_nxt[l] = w_mag[l];
            end
            w_par_nxt[l] = r_par[l] ^ w_sgn[l];
            w_sign0[l]   = (r_col == '0) ? w_sgn[l] : r_sign_buf[0][l];
            w_first[l]   = msg('0, w_idx_nxt[l], w_min1_nxt[l], w_min2_nxt[l],
                               w_par_nxt[l] ^ w_sign0[l]);
            w_next[l]    = msg(w_jn, r_idx[l], r_min1[l], r_min2[l],
                               r_par[l] ^ r_sign_buf[w_jn][l]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ACCUM;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            ACCUM: begin
                in_ready = 1'b1;
                if (w_last_acc)
                    w_state_nxt = EMIT;
            end
            EMIT: begin
                if (w_done)
                    w_state_nxt = ACCUM;
            end
            default: w_state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < LiftingFactor; l++) begin
                r_min1[l]   <= c_MAG_MAX;
                r_min2[l]   <= c_MAG_MAX;
                r_idx[l]    <= '0;
                out_data[l] <= '0;
            end
            for (int c = 0; c < MAX_DEG; c++)
                r_sign_buf[c] <= '0;
            r_par      <= '0;
            r_col      <= '0;
            r_last_col <= '0;
            r_j        <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            deg_err    <= 1'b0;
        end else begin
            if (w_acc) begin
                for (int l = 0; l < LiftingFactor; l++) begin
                    r_min1[l] <= w_min1_nxt[l];
                    r_min2[l] <= w_min2_nxt[l];
                    r_idx[l]  <= w_idx_nxt[l];
                end
                r_par             <= w_par_nxt;
                r_sign_buf[r_col] <= w_sgn;
                if ((r_col == c_LAST_COL) && !in_last)
                    deg_err <= 1'b1;
                if (w_last_acc) begin
                    // Store the last column index rather than the degree so it fits c_IW bits.
                    r_last_col <= r_col;
                    r_col      <= '0;
                    r_j        <= '0;
                    out_valid  <= 1'b1;
                    out_last   <= (r_col == '0);
                    for (int l = 0; l < LiftingFactor; l++)
                        out_data[l] <= w_first[l];
                end else begin
                    r_col <= r_col + c_IW'(1);
                end
            end
            if (w_hs) begin
                if (out_last) begin
                    for (int l = 0; l < LiftingFactor; l++) begin
                        r_min1[l]   <= c_MAG_MAX;
                        r_min2[l]   <= c_MAG_MAX;
                        r_idx[l]    <= '0;
                        out_data[l] <= '0;
                    end
                    r_par     <= '0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end else begin
                    r_j      <= w_jn;
                    out_last <= (w_jn == r_last_col);
                    for (int l = 0; l < LiftingFactor; l++)
                        out_data[l] <= w_next[l];
                end
            end
        end
    end

endmodule
`default_nettype wire
